counter_updown_8: RTL and testbench
===================================

# counter_updown_8

8-bit synchronous up/down counter with parallel load and asynchronous clear, modelled as a discrete counter chip (74HC161/191-class behaviour widened to 8 bits). It holds the program counter or stack pointer value in the emulated CPU. Its `q` outputs feed quad tri-state buffer chips directly, and those buffers gate the value onto the shared 8-bit bus. `tc` and `rco_n` allow cascading to a second counter for 16-bit address spans.

## Interface
Parameters:
- `RESET_VALUE`, default 8'h00: value loaded into `q` on reset.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge except reset.
- `reset` in 1: asynchronous, active-high clear; forces `q` = `RESET_VALUE` immediately.
- `d` in 8: parallel load data, normally taken from the bus.
- `ld_n` in 1: active-low synchronous load.
- `cnt_en` in 1: active-high count enable.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `q` out 8: registered counter value.
- `tc` out 1: terminal count, combinational. High when (`up`=1 and `q`=8'hFF) or (`up`=0 and `q`=8'h00).
- `rco_n` out 1: active-low ripple carry/borrow, combinational = ~(`tc` & `cnt_en`).

## Operation
- Register state: `q` only. The per-edge mode is selected in this priority order:
  1. RESET: `reset`=1 forces `q` = `RESET_VALUE` asynchronously, regardless of `clk`, `ld_n` or `cnt_en`.
  2. LOAD: `ld_n`=0 sets `q` ← `d` on the rising edge. Load overrides counting even when `cnt_en`=1.
  3. COUNT: `ld_n`=1 and `cnt_en`=1 sets `q` ← `q`+1 when `up`=1, or `q` ← `q`−1 when `up`=0. Arithmetic is modulo 256.
  4. HOLD: `ld_n`=1 and `cnt_en`=0 leaves `q` unchanged.
- Wrap-around:
  - Counting up from 8'hFF gives 8'h00.
  - Counting down from 8'h00 gives 8'hFF.
  - The edge that wraps is exactly the edge on which `rco_n` was low.
- `tc` depends only on `q` and `up`, not on `cnt_en`. `rco_n` additionally requires `cnt_en`=1.
- Cascading: the upper counter's `cnt_en` connects to the lower counter's ~`rco_n`. Both counters share `clk`, `reset`, `up` and `ld_n`.
- Direction changes take effect on the next counting edge. `tc` and `rco_n` re-evaluate combinationally as soon as `up` changes.
- `d` is ignored unless `ld_n`=0 at the edge. `up` is ignored unless counting.
- The block has no tri-state outputs. `q` is always driven, and bus gating is the downstream buffer's responsibility.

## Timing
- Reset values: `q` = `RESET_VALUE`. With the default `RESET_VALUE`, `tc` = ~`up` and `rco_n` = ~(~`up` & `cnt_en`).
- Reset assertion: `q` changes in the same simulation time step, with no clock needed. Releasing `reset` has no effect until the next rising edge.
- If `reset` is still high at a rising edge, that edge is ignored. If a load or count is requested on that edge, `q` stays `RESET_VALUE`.
- Latency:
  - Load and count: one rising edge; the new `q` is visible after the edge.
  - `tc` and `rco_n`: combinational, zero cycles from `q`, `up` and `cnt_en`.
- Inputs are sampled on the rising edge. No handshake; every enabled edge completes unconditionally.
- Simultaneous `ld_n`=0 and `cnt_en`=1: load wins, and no increment is applied to the loaded value.

## Test plan
- Reset and hold:
  - Assert `reset` mid-cycle with `q`=8'h5A → `q`=8'h00 before the next edge.
  - Release `reset`, then hold `cnt_en`=0 for 3 edges → `q` stays 8'h00.
- Load priority: `d`=8'hA5, `ld_n`=0, `cnt_en`=1, `up`=1, one edge → `q`=8'hA5 (not 8'hA6). Next edge with `ld_n`=1 → `q`=8'hA6.
- Up wrap:
  - Load 8'hFE, count up with `up`=1 → edge 1 gives `q`=8'hFF, `tc`=1, `rco_n`=0.
  - Edge 2 → `q`=8'h00, `tc`=0, `rco_n`=1.
- Down wrap and direction flip:
  - Load 8'h01, `up`=0, count → `q`=8'h00, `tc`=1. Next edge → 8'hFF.
  - Set `up`=1 with `q`=8'hFF → `tc`=1 immediately, with no edge. Next count edge → 8'h00.
- Cascade: two instances chained as 16 bits, load 16'h00FF, count up one edge → 16'h0100. Then `up`=0, one edge → 16'h00FF.
- Reset during activity: count continuously from 8'h10. Assert `reset` for 2 edges → `q`=8'h00 held. Release → counting resumes: 8'h01, 8'h02.

Source files
------------

// File: rtl/counter_updown_8.sv
// 8-bit up/down counter with synchronous parallel load and asynchronous clear.
// tc/rco_n are combinational so that two instances can be cascaded.
module counter_updown_8 #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       ld_n,
  input  logic       cnt_en,
  input  logic       up,
  output logic [7:0] q,
  output logic       tc,
  output logic       rco_n
);

  logic [7:0] r_q;
  logic       w_tc;

  // Load has priority over counting; reset still high at an edge wins over both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (!ld_n) begin
      r_q <= d;
    end else if (cnt_en) begin
      if (up) r_q <= r_q + 8'd1;
      else    r_q <= r_q - 8'd1;
    end
  end

  assign w_tc  = up ? (r_q == 8'hFF) : (r_q == 8'h00);
  assign q     = r_q;
  assign tc    = w_tc;
  assign rco_n = ~(w_tc & cnt_en);

endmodule

// File: tb/tb_counter_updown_8.sv
// Directed self-checking bench for counter_updown_8, including a 16-bit
// cascade and a non-default RESET_VALUE instance.
module tb_counter_updown_8;

  logic       clk;
  logic       reset;
  logic [7:0] d;
  logic       ld_n;
  logic       cnt_en;
  logic       up;
  logic [7:0] q;
  logic       tc;
  logic       rco_n;

  logic [7:0] d_lo, d_hi, q_lo, q_hi, q_rv;
  logic       tc_lo, rco_n_lo, tc_hi, rco_n_hi, tc_rv, rco_n_rv;
  logic       cnt_en_hi;

  int n_total = 0;
  int n_pass  = 0;

  counter_updown_8 dut (
    .clk(clk), .reset(reset), .d(d), .ld_n(ld_n), .cnt_en(cnt_en), .up(up),
    .q(q), .tc(tc), .rco_n(rco_n)
  );

  counter_updown_8 u_lo (
    .clk(clk), .reset(reset), .d(d_lo), .ld_n(ld_n), .cnt_en(cnt_en), .up(up),
    .q(q_lo), .tc(tc_lo), .rco_n(rco_n_lo)
  );

  assign cnt_en_hi = ~rco_n_lo;

  counter_updown_8 u_hi (
    .clk(clk), .reset(reset), .d(d_hi), .ld_n(ld_n), .cnt_en(cnt_en_hi), .up(up),
    .q(q_hi), .tc(tc_hi), .rco_n(rco_n_hi)
  );

  counter_updown_8 #(.RESET_VALUE(8'hC3)) u_rv (
    .clk(clk), .reset(reset), .d(d), .ld_n(ld_n), .cnt_en(cnt_en), .up(up),
    .q(q_rv), .tc(tc_rv), .rco_n(rco_n_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; d = 8'h00; ld_n = 1'b1; cnt_en = 1'b0; up = 1'b1;
    d_lo = 8'h00; d_hi = 8'h00;
    #1 reset = 1'b1;
    tick(); tick();
    check("rst_q", {8'h0, q}, 16'h0000);
    check("rst_tc_up1", {15'h0, tc}, 16'h0000);
    check("rst_rco_n", {15'h0, rco_n}, 16'h0001);
    check("rst_value_param", {8'h0, q_rv}, 16'h00C3);

    // load 5A, then clear asynchronously mid-cycle
    reset = 1'b0;
    ld_n = 1'b0; d = 8'h5A;
    tick();
    ld_n = 1'b1;
    check("load_5a", {8'h0, q}, 16'h005A);
    #2 reset = 1'b1;
    #1 check("async_clear", {8'h0, q}, 16'h0000);
    reset = 1'b0;
    d = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", {8'h0, q}, 16'h0000);
    end

    up = 1'b0;
    #1 check("tc_down_at_00", {15'h0, tc}, 16'h0001);
    check("rco_n_no_en", {15'h0, rco_n}, 16'h0001);
    cnt_en = 1'b1;
    #1 check("rco_n_en", {15'h0, rco_n}, 16'h0000);
    cnt_en = 1'b0; up = 1'b1;

    // load priority over count
    d = 8'hA5; ld_n = 1'b0; cnt_en = 1'b1; up = 1'b1;
    tick();
    check("load_wins", {8'h0, q}, 16'h00A5);
    ld_n = 1'b1;
    tick();
    check("count_after_load", {8'h0, q}, 16'h00A6);

    // up wrap
    ld_n = 1'b0; d = 8'hFE;
    tick();
    ld_n = 1'b1;
    check("load_fe", {8'h0, q}, 16'h00FE);
    tick();
    check("up_ff_q", {8'h0, q}, 16'h00FF);
    check("up_ff_tc", {15'h0, tc}, 16'h0001);
    check("up_ff_rco_n", {15'h0, rco_n}, 16'h0000);
    tick();
    check("up_wrap_q", {8'h0, q}, 16'h0000);
    check("up_wrap_tc", {15'h0, tc}, 16'h0000);
    check("up_wrap_rco_n", {15'h0, rco_n}, 16'h0001);

    // down wrap and direction flip
    ld_n = 1'b0; d = 8'h01; up = 1'b0;
    tick();
    ld_n = 1'b1;
    check("load_01", {8'h0, q}, 16'h0001);
    tick();
    check("down_00_q", {8'h0, q}, 16'h0000);
    check("down_00_tc", {15'h0, tc}, 16'h0001);
    tick();
    check("down_wrap_q", {8'h0, q}, 16'h00FF);
    check("down_ff_tc", {15'h0, tc}, 16'h0000);
    up = 1'b1;
    #1 check("flip_tc", {15'h0, tc}, 16'h0001);
    check("flip_rco_n", {15'h0, rco_n}, 16'h0000);
    tick();
    check("flip_count", {8'h0, q}, 16'h0000);

    // 16-bit cascade
    ld_n = 1'b0; d_hi = 8'h00; d_lo = 8'hFF; cnt_en = 1'b1; up = 1'b1;
    tick();
    ld_n = 1'b1;
    check("casc_load", {q_hi, q_lo}, 16'h00FF);
    tick();
    check("casc_up", {q_hi, q_lo}, 16'h0100);
    up = 1'b0;
    tick();
    check("casc_down", {q_hi, q_lo}, 16'h00FF);

    // reset during continuous counting
    ld_n = 1'b0; d = 8'h10; up = 1'b1;
    tick();
    ld_n = 1'b1;
    tick();
    check("run_11", {8'h0, q}, 16'h0011);
    tick();
    check("run_12", {8'h0, q}, 16'h0012);
    reset = 1'b1;
    #1 check("run_rst_now", {8'h0, q}, 16'h0000);
    tick();
    check("run_rst_edge1", {8'h0, q}, 16'h0000);
    tick();
    check("run_rst_edge2", {8'h0, q}, 16'h0000);
    reset = 1'b0;
    tick();
    check("resume_01", {8'h0, q}, 16'h0001);
    tick();
    check("resume_02", {8'h0, q}, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
